// File: rtl/imem_boot_controller_pkg.sv
// Shared definitions for the instruction-memory boot controller: FSM encoding
// and the fixed constants used by the top level and the byte packer.
package imem_boot_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StWrite = 2'd2,
    StRun   = 2'd3
  } state_e;

  localparam int unsigned DefaultAddrW = 10;
  localparam logic [31:0] NopWord      = 32'h0000_0000;
  localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs an accepted byte stream MSB-first into 32-bit words; word_valid_o
// strobes on the byte that completes a word.
module imem_byte_packer
  import imem_boot_controller_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned CntW = $clog2(BytesPerWord);
  localparam logic [CntW-1:0] LastByte = CntW'(BytesPerWord - 1);

  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]     word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (byte_valid_i) begin
      word_d     = {word_q[23:0], byte_i};
      byte_cnt_d = (byte_cnt_q == LastByte) ? '0 : byte_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == LastByte);

endmodule

// File: rtl/imem_boot_controller.sv
// Boot-load / run sequencer for the instruction memory: streams bytes into
// consecutive words while the CPU is stalled, then routes the PC to memory.
module imem_boot_controller
  import imem_boot_controller_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_we_o,
  output logic [31:0]       imem_wdata_o,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instruction_o,
  output logic              cpu_stall_o,
  output logic              load_done_o,
  output logic              load_error_o,
  output logic              fetch_fault_o
);

  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              load_done_q, load_done_d;
  logic              load_error_q, load_error_d;

  logic              pack_clear;
  logic              pack_accept;
  logic [31:0]       pack_word;
  logic              pack_word_valid;

  assign pack_accept = rx_valid_i && (state_q == StLoad);

  imem_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_accept),
    .byte_i       (rx_data_i),
    .word_o       (pack_word),
    .word_valid_o (pack_word_valid)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    wr_addr_d    = wr_addr_q;
    load_done_d  = 1'b0;
    load_error_d = load_error_q;
    pack_clear   = 1'b0;
    unique case (state_q)
      // RUN shares the IDLE length check so a reload can start straight from RUN.
      StIdle, StRun: begin
        if (load_start_i) begin
          if (load_len_i == '0) begin
            state_d      = StRun;
            load_done_d  = 1'b1;
            load_error_d = 1'b0;
          end else if (load_len_i <= MaxLen) begin
            state_d      = StLoad;
            len_d        = load_len_i;
            word_cnt_d   = '0;
            wr_addr_d    = '0;
            load_error_d = 1'b0;
            pack_clear   = 1'b1;
          end else begin
            state_d      = StIdle;
            load_error_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (pack_word_valid) state_d = StWrite;
      end
      StWrite: begin
        wr_addr_d  = wr_addr_q + 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_q + 1'b1 == len_q) begin
          state_d     = StRun;
          load_done_d = 1'b1;
        end else begin
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      len_q        <= '0;
      word_cnt_q   <= '0;
      wr_addr_q    <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      wr_addr_q    <= wr_addr_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  logic in_run;
  assign in_run = (state_q == StRun);

  assign cpu_stall_o   = !in_run;
  assign rx_ready_o    = (state_q == StLoad);
  assign imem_we_o     = (state_q == StWrite);
  assign imem_wdata_o  = (state_q == StWrite) ? pack_word : '0;
  assign load_done_o   = load_done_q;
  assign load_error_o  = load_error_q;

  assign imem_addr_o   = in_run ? pc_i[ADDR_W+1:2] : wr_addr_q;
  assign instruction_o = in_run ? imem_rdata_i : NOP_WORD;
  assign fetch_fault_o = in_run && ((pc_i[1:0] != 2'b00) || ((pc_i >> (ADDR_W + 2)) != '0));

endmodule

// File: tb/tb_imem_boot_controller.sv
// Directed bench for imem_boot_controller with a behavioural instruction memory.
module tb_imem_boot_controller;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [31:0]   pc;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;
  logic [31:0]   imem_rdata;
  logic [31:0]   instruction;
  logic          cpu_stall;
  logic          load_done;
  logic          load_error;
  logic          fetch_fault;

  always #5 clk = ~clk;

  imem_boot_controller #(
    .ADDR_W   (AW),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .load_start_i  (load_start),
    .load_len_i    (load_len),
    .rx_valid_i    (rx_valid),
    .rx_data_i     (rx_data),
    .rx_ready_o    (rx_ready),
    .pc_i          (pc),
    .imem_addr_o   (imem_addr),
    .imem_we_o     (imem_we),
    .imem_wdata_o  (imem_wdata),
    .imem_rdata_i  (imem_rdata),
    .instruction_o (instruction),
    .cpu_stall_o   (cpu_stall),
    .load_done_o   (load_done),
    .load_error_o  (load_error),
    .fetch_fault_o (fetch_fault)
  );

  // Unwritten words read back as A000_0000 | address so stray reads are visible.
  logic [31:0] mem     [1024];
  bit          written [1024];
  int          we_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] log_data [16];
  logic [AW-1:0] log_addr [16];

  assign imem_rdata = written[imem_addr] ? mem[imem_addr] : (32'hA000_0000 | 32'(imem_addr));

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_addr]     <= imem_wdata;
      written[imem_addr] <= 1'b1;
      if (we_cnt < 16) begin
        log_addr[we_cnt] <= imem_addr;
        log_data[we_cnt] <= imem_wdata;
      end
      we_cnt <= we_cnt + 1;
    end
    if (load_done) done_cnt <= done_cnt + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a byte and holds it until one accepting edge has passed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      step();
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", {31'b0, rx_ready}, 32'd1);
    step();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!load_done && n < 30) begin
      step();
      n++;
    end
    chk("load_done_seen", {31'b0, load_done}, 32'd1);
  endtask

  task automatic start_load(input logic [AW:0] len);
    load_start = 1'b1;
    load_len   = len;
    step();
    load_start = 1'b0;
  endtask

  typedef struct {
    logic [31:0]   pc;
    logic [AW-1:0] addr;
    logic [31:0]   instr;
    logic          fault;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h0000_0000, 10'd0,   32'h2001_0005, 1'b0};
    vecs[1] = '{32'h0000_0004, 10'd1,   32'h2002_0007, 1'b0};
    vecs[2] = '{32'h0000_0006, 10'd1,   32'h2002_0007, 1'b1};
    vecs[3] = '{32'h0000_0008, 10'd2,   32'hA000_0002, 1'b0};
    vecs[4] = '{32'h0000_0FFC, 10'h3FF, 32'hA000_03FF, 1'b0};
    vecs[5] = '{32'h0000_1000, 10'd0,   32'h2001_0005, 1'b1};
    vecs[6] = '{32'h8000_0004, 10'd1,   32'h2002_0007, 1'b1};
    vecs[7] = '{32'h0000_0003, 10'd0,   32'h2001_0005, 1'b1};

    rst_n      = 1'b0;
    load_start = 1'b0;
    load_len   = '0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    pc         = '0;

    // Reset state
    step();
    step();
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("rst_imem_we", {31'b0, imem_we}, 32'd0);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_load_error", {31'b0, load_error}, 32'd0);
    chk("rst_load_done", {31'b0, load_done}, 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1;
    step();

    // Two-word continuous load
    start_load(11'd2);
    chk("load_rx_ready", {31'b0, rx_ready}, 32'd1);
    send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    chk("write_cycle_we", {31'b0, imem_we}, 32'd1);
    chk("write_cycle_rx_ready", {31'b0, rx_ready}, 32'd0);
    send_byte(8'h20); send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    rx_valid = 1'b0;
    wait_done();
    chk("run_cpu_stall", {31'b0, cpu_stall}, 32'd0);
    step();
    chk("load_done_pulse_width", {31'b0, load_done}, 32'd0);
    chk("two_word_we_cnt", 32'(we_cnt), 32'd2);
    chk("two_word_done_cnt", 32'(done_cnt), 32'd1);
    chk("w0_addr", 32'(log_addr[0]), 32'd0);
    chk("w0_data", log_data[0], 32'h2001_0005);
    chk("w1_addr", 32'(log_addr[1]), 32'd1);
    chk("w1_data", log_data[1], 32'h2002_0007);

    // Run-phase PC routing table
    for (int i = 0; i < 8; i++) begin
      pc = vecs[i].pc;
      #1;
      chk($sformatf("vec%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_instruction", i), instruction, vecs[i].instr);
      chk($sformatf("vec%0d_fetch_fault", i), {31'b0, fetch_fault}, {31'b0, vecs[i].fault});
    end
    pc = 32'h0;

    // Reload from RUN with a gapped one-word stream
    start_load(11'd1);
    chk("reload_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    chk("reload_instr_nop", instruction, 32'h0);
    chk("reload_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    send_byte(8'hDE); rx_valid = 1'b0; step();
    send_byte(8'hAD); rx_valid = 1'b0; step();
    send_byte(8'hBE); rx_valid = 1'b0; step();
    chk("gapped_no_early_we", 32'(we_cnt), 32'd2);
    send_byte(8'hEF); rx_valid = 1'b0;
    wait_done();
    chk("gapped_we_cnt", 32'(we_cnt), 32'd3);
    chk("gapped_addr", 32'(log_addr[2]), 32'd0);
    chk("gapped_data", log_data[2], 32'hDEAD_BEEF);
    #1;
    chk("gapped_readback", instruction, 32'hDEAD_BEEF);
    step();

    // Oversized length from RUN
    start_load(11'd1025);
    chk("err_flag", {31'b0, load_error}, 32'd1);
    chk("err_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    step();
    chk("err_stays_idle", {31'b0, rx_ready}, 32'd0);
    chk("err_sticky", {31'b0, load_error}, 32'd1);

    // Maximum legal length is accepted and clears the error
    start_load(11'd1024);
    chk("maxlen_rx_ready", {31'b0, rx_ready}, 32'd1);
    chk("maxlen_err_cleared", {31'b0, load_error}, 32'd0);

    // Reset after two bytes abandons the load
    send_byte(8'h11); send_byte(8'h22); rx_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_rx_ready", {31'b0, rx_ready}, 32'd0);
    chk("midrst_cpu_stall", {31'b0, cpu_stall}, 32'd1);
    chk("midrst_no_we", 32'(we_cnt), 32'd3);
    step();
    start_load(11'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    rx_valid = 1'b0;
    wait_done();
    chk("post_rst_we_cnt", 32'(we_cnt), 32'd4);
    chk("post_rst_addr", 32'(log_addr[3]), 32'd0);
    chk("post_rst_data", log_data[3], 32'h0102_0304);
    step();

    // Zero-length load from RUN: straight back to RUN with a done pulse
    start_load(11'd0);
    chk("zero_len_done", {31'b0, load_done}, 32'd1);
    chk("zero_len_run", {31'b0, cpu_stall}, 32'd0);
    step();
    chk("zero_len_no_we", 32'(we_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_controller.md
Name: imem_boot_controller

Overview:
- Sequences the instruction memory between a boot-load phase and a run phase.
- During boot it takes a byte stream over a valid/ready link, packs the bytes big-endian into 32-bit words and writes them to consecutive word addresses. The CPU is held stalled throughout.
- During run it routes the CPU PC onto the memory address port and returns the fetched instruction. This replaces file-based memory preloading with in-system programming.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words.
- NOP_WORD, 32'h0000_0000, instruction returned to the CPU whenever not in RUN.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- load_start  in  1  single-cycle request to begin a (re)load
- load_len  in  ADDR_W+1  number of words to load; sampled with load_start
- rx_valid  in  1  byte-stream valid
- rx_data  in  8  byte-stream data
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- pc  in  32  CPU byte address
- imem_addr  out  ADDR_W  word address to instruction memory
- imem_we  out  1  instruction memory write enable
- imem_wdata  out  32  write data
- imem_rdata  in  32  combinational read data, from imem_addr
- instruction  out  32  instruction to CPU
- cpu_stall  out  1  CPU must hold PC and not retire
- load_done  out  1  one-cycle pulse when a load completes
- load_error  out  1  sticky error flag; cleared by the next accepted load_start
- fetch_fault  out  1  combinational; pc misaligned or beyond depth, only in RUN

Behaviour:
- States: IDLE, LOAD, WRITE, RUN.
- Reset (rst_n=0 at posedge):
  - state=IDLE, byte_cnt=0, word_cnt=0, wr_addr=0, shift register=0.
  - Outputs: rx_ready=0, imem_we=0, imem_wdata=0, imem_addr=0, load_done=0, load_error=0, cpu_stall=1, instruction=NOP_WORD.
  - Reset mid-load abandons the load. Words already written stay in memory; nothing is rolled back.
- IDLE:
  - cpu_stall=1.
  - On load_start with 0 < load_len <= 2**ADDR_W: latch the length, clear counters and load_error, go to LOAD.
  - On load_start with load_len=0: go to RUN and pulse load_done; memory is untouched.
  - On load_start with load_len > 2**ADDR_W: set load_error, stay in IDLE.
- LOAD:
  - rx_ready=1.
  - Each accepted byte shifts in MSB-first: word = {word[23:0], rx_data}, so byte0 lands in bits 31:24. byte_cnt increments.
  - On the 4th byte, byte_cnt wraps to 0 and the state goes to WRITE next cycle.
  - load_start is ignored while in LOAD.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=wr_addr, imem_wdata=packed word, rx_ready=0.
  - wr_addr and word_cnt increment.
  - If word_cnt+1 == latched length: go to RUN and assert load_done in the first RUN cycle. Otherwise return to LOAD.
  - Per-word throughput: 4 accepted bytes + 1 write cycle. Minimum 5 cycles per word.
- RUN:
  - cpu_stall=0, rx_ready=0, imem_we=0.
  - imem_addr = pc[ADDR_W+1:2]; instruction = imem_rdata, zero added latency.
  - fetch_fault=1 if pc[1:0]!=0 or pc[31:ADDR_W+2]!=0; instruction is still passed through.
  - load_start (any load_len) re-enters the IDLE length check in the same cycle. cpu_stall rises on the next cycle, and instruction becomes NOP_WORD from that cycle on.
- Outside RUN: imem_addr=wr_addr and instruction=NOP_WORD.
- wr_addr wraps naturally at 2**ADDR_W. The length check guarantees no overwrite within one load.
- rx_valid while rx_ready=0 is not consumed; the source must hold the byte.
- All control outputs (cpu_stall, rx_ready, imem_we, imem_wdata, load_done, load_error) are registered/state-decoded. Data-path muxing (imem_addr, instruction, fetch_faultuncovered) is combinational.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, RUN=2'd3);
  - NOP_WORD;
  - the default ADDR_W;
  - the byte-per-word constant 4.
- One natural sub-module: imem_byte_packer (4-byte shift/pack with byte counter and word_valid strobe). The FSM and address/mux logic stay in the top.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> cpu_stall=1, rx_ready=0, imem_we=0, instruction=0, load_error=0.
- load_start, load_len=2; stream bytes 20,01,00,05,20,02,00,07 continuously -> imem_we pulses twice: addr0=32'h20010005, addr1=32'h20020007. load_done pulses once, then cpu_stall=0.
- In RUN, pc=32'h4 with memory model -> imem_addr=1, instruction=32'h20020007, fetch_fault=0. pc=32'h6 -> fetch_fault=1.
- Gapped stream: rx_valid toggling every other cycle, load_len=1 -> word still packs correctly, with exactly one write after the 4th accepted byte.
- load_start with load_len=1025 (ADDR_W=10) -> load_error=1, stays stalled. A following valid load_start clears load_error.
- Reset asserted after 2 bytes of a load -> IDLE, no imem_we. A new load then starts packing at byte_cnt=0, addr 0.
